// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: FSM states,
// register offsets, CTRL bit layout and mode decoding.
package timer_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timerState_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Modes 2 and 3 are reserved and fall back to one-shot.
  function automatic logic [1:0] decodeMode(input logic [1:0] mode);
    return (mode == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides CNT-state cycles down to one decrement tick every PRESCALE cycles.
// Only instantiated by timer_dev when TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase <= '0;
    end else if (run) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

  assign tick = run && (phase == LAST);

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Optional build macro TIMER_PRESCALE_EN slows the count by PRESCALE cycles per step.
module timer_dev
  import timer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Addr,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              IRQ
);

  timerState_t       state, stateNext;
  logic [3:0]        ctrl;
  logic [DATA_W-1:0] preset, count, countNext;
  logic              irqFlag, irqNext, enNext;
  logic              cpuWrite, tick;

  assign cpuWrite = WE && (Addr == ADDR_CTRL || Addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
  logic preClear, preRun;

  assign preClear = (state == LOAD) || cpuWrite;
  assign preRun   = (state == CNT);

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) uPrescaler (
    .clk  (clk),
    .reset(reset),
    .clear(preClear),
    .run  (preRun),
    .tick (tick)
  );
`else
  // Every CNT cycle is a decrement step; PRESCALE has no effect in this build.
  assign tick = (PRESCALE > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      irqFlag <= 1'b0;
    end else begin
      state   <= stateNext;
      count   <= countNext;
      irqFlag <= irqNext;
      if (WE && Addr == ADDR_CTRL) begin
        ctrl <= Din[3:0];
      end else begin
        ctrl[CTRL_EN] <= enNext;
      end
      if (WE && Addr == ADDR_PRESET) begin
        preset <= Din;
      end
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    irqNext   = irqFlag;
    enNext    = ctrl[CTRL_EN];
    case (state)
      IDLE: begin
        if (ctrl[CTRL_EN]) stateNext = LOAD;
      end
      LOAD: begin
        countNext = preset;
        stateNext = CNT;
      end
      CNT: begin
        if (!ctrl[CTRL_EN]) begin
          stateNext = IDLE;
        end else if (tick) begin
          // A preset of 0 expires like a preset of 1; COUNT never wraps.
          if (count <= DATA_W'(1)) begin
            countNext = '0;
            irqNext   = 1'b1;
            stateNext = INT;
          end else begin
            countNext = count - 1'b1;
          end
        end
      end
      INT: begin
        if (decodeMode(ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB]) == MODE_RELOAD) begin
          irqNext   = 1'b0;
          stateNext = LOAD;
        end else begin
          enNext    = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // CPU register writes take the edge: restart from IDLE, drop the flag, keep COUNT.
    if (cpuWrite) begin
      stateNext = IDLE;
      irqNext   = 1'b0;
      countNext = count;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = {{(DATA_W-4){1'b0}}, ctrl};
      ADDR_PRESET: Dout = preset;
      ADDR_COUNT:  Dout = count;
      default:     Dout = '0;
    endcase
  end

  assign IRQ = irqFlag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: a timeline model of the timer checked every cycle,
// plus hand-computed literal expectations at the key points of each scenario.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic        IRQ;

  int vectors = 0;
  int miscompares = 0;

`ifdef TIMER_PRESCALE_EN
  localparam longint MP = 4;
`else
  localparam longint MP = 1;
`endif

  timer_dev #(.PRESCALE(4)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  // Model state: register contents plus edges elapsed since the timer was (re)started.
  logic [3:0]  mCtrl = 4'd0;
  logic [31:0] mPreset = 32'd0;
  logic [31:0] mCount = 32'd0;
  logic        mFlag = 1'b0;
  longint      mK = 0;

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, mCtrl};
      2'd1:    return mPreset;
      2'd2:    return mCount;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    longint nEff, run, j;
    logic [31:0] expDout;
    logic        expIrq;
    forever begin
      @(posedge clk);
      if (reset) begin
        mCtrl = 4'd0; mPreset = 32'd0; mCount = 32'd0; mFlag = 1'b0; mK = 0;
      end else if (WE && (Addr == 2'd0 || Addr == 2'd1)) begin
        if (Addr == 2'd0) mCtrl = Din[3:0];
        else mPreset = Din;
        mFlag = 1'b0;
        mK = 0;
      end else if (mCtrl[0]) begin
        // Edge 1 leaves IDLE, edge 2 loads, then N*MP counting edges, then INT.
        mK++;
        if (mK >= 2) begin
          nEff = (mPreset == 32'd0) ? 1 : longint'(mPreset);
          run  = nEff * MP;
          j    = mK - 2;
          if (mCtrl[2:1] == 2'd1) j = j % (run + 2);
          if (j < run) mCount = 32'(longint'(mPreset) - j / MP);
          else if (j == run) begin mCount = 32'd0; mFlag = 1'b1; end
          else if (mCtrl[2:1] == 2'd1) mFlag = 1'b0;
          else mCtrl[0] = 1'b0;
        end
      end
      #1;
      expIrq  = mFlag & mCtrl[3];
      expDout = modelRead(Addr);
      vectors++;
      if (IRQ !== expIrq) begin
        miscompares++;
        $display("FAIL cycle_irq t=%0t: got %0b, expected %0b", $time, IRQ, expIrq);
      end
      vectors++;
      if (Dout !== expDout) begin
        miscompares++;
        $display("FAIL cycle_dout t=%0t addr=%0d: got %h, expected %h", $time, Addr, Dout, expDout);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic readChk(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(name, Dout, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    WE = 1'b1; Addr = a; Din = d;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_irq", {31'd0, IRQ}, 32'd0);
    readChk("reset_ctrl", 2'd0, 32'd0);
    readChk("reset_preset", 2'd1, 32'd0);
    readChk("reset_count", 2'd2, 32'd0);
    reset = 1'b0;

    // One-shot: PRESET 5 expires 7 edges after the CTRL write.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    Addr = 2'd2;
    idle(6);
    chk("oneshot_irq_e6", {31'd0, IRQ}, 32'd0);
    idle(1);
    chk("oneshot_irq_e7", {31'd0, IRQ}, 32'd1);
    readChk("oneshot_count", 2'd2, 32'd0);
    idle(2);
    readChk("oneshot_ctrl", 2'd0, 32'h8);
    chk("oneshot_irq_hold", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h8);
    chk("oneshot_irq_clear", {31'd0, IRQ}, 32'd0);

    // Auto-reload: PRESET 3 gives a one-cycle pulse every 5 edges.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    Addr = 2'd2;
    idle(2);
    readChk("reload_count_e2", 2'd2, 32'd3);
    idle(1);
    readChk("reload_count_e3", 2'd2, 32'd2);
    idle(2);
    chk("reload_irq_e5", {31'd0, IRQ}, 32'd1);
    readChk("reload_count_e5", 2'd2, 32'd0);
    idle(1);
    chk("reload_irq_e6", {31'd0, IRQ}, 32'd0);
    idle(1);
    readChk("reload_count_e7", 2'd2, 32'd3);
    idle(3);
    chk("reload_irq_e10", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h0);

    // Masked: flag sets internally but IRQ never rises.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    idle(4);
    chk("mask_irq_e4", {31'd0, IRQ}, 32'd0);
    idle(2);
    readChk("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk("mask_irq_after_im", {31'd0, IRQ}, 32'd0);

    // Pause at COUNT=10, then restart reloads PRESET rather than resuming.
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    Addr = 2'd2;
    idle(12);
    readChk("pause_count_before", 2'd2, 32'd10);
    wr(2'd0, 32'h8);
    readChk("pause_count_frozen", 2'd2, 32'd10);
    idle(3);
    readChk("pause_count_still", 2'd2, 32'd10);
    wr(2'd0, 32'h9);
    idle(2);
    readChk("restart_count_load", 2'd2, 32'd20);
    idle(3);
    readChk("restart_count_e5", 2'd2, 32'd17);
    wr(2'd0, 32'h8);
    readChk("stop_count", 2'd2, 32'd17);

    // Writes to COUNT and the unused slot are ignored; the unused slot reads 0.
    wr(2'd2, 32'hFFFF_FFFF);
    readChk("count_write_ignored", 2'd2, 32'd17);
    wr(2'd3, 32'h1234_5678);
    readChk("addr3_reads_zero", 2'd3, 32'd0);
    readChk("addr3_preset_kept", 2'd1, 32'd20);
    readChk("addr3_ctrl_kept", 2'd0, 32'h8);

    // PRESET 0 behaves as 1: IRQ three edges after the write.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    idle(2);
    chk("preset0_irq_e2", {31'd0, IRQ}, 32'd0);
    idle(1);
    chk("preset0_irq_e3", {31'd0, IRQ}, 32'd1);

    // Reset while in INT with IRQ high.
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_irq", {31'd0, IRQ}, 32'd0);
    readChk("midreset_ctrl", 2'd0, 32'd0);
    readChk("midreset_preset", 2'd1, 32'd0);
    readChk("midreset_count", 2'd2, 32'd0);
    reset = 1'b0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
